// File: rtl/bdr_param_if.sv
// Bundled register-bank access signals: write port, two read ports, read data and ready.
// The master drives the requests and the slave (the bank) returns data and status.
interface bdr_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] RR1;
    logic [ADDR_W-1:0] RR2;
    logic [ADDR_W-1:0] WA;
    logic [DATA_W-1:0] WD;
    logic [DATA_W-1:0] DR1;
    logic [DATA_W-1:0] DR2;
    logic              ready;

    modport master (
        output RegWrite, RR1, RR2, WA, WD,
        input  DR1, DR2, ready
    );

    modport slave (
        input  RegWrite, RR1, RR2, WA, WD,
        output DR1, DR2, ready
    );
endinterface

// File: rtl/bdr_param.sv
// Parameterised two-read/one-write register bank with registered read data.
// After reset it clears every entry with a hardware sweep before raising ready.
module bdr_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    bdr_param_if.slave  bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              sweep_en_s;
    logic              ready_r;
    logic              ready_nxt_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] dr1_r;
    logic [DATA_W-1:0] dr2_r;

    // Next-state logic: the sweep counter walks every entry once, then the bank runs
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sweep_en_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                sweep_en_s = 1'b1;
                cnt_nxt_s  = cnt_r + ADDR_W'(1'b1);
                if (cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_INIT;
                cnt_nxt_s   = ADDR_ZERO;
            end
        endcase
        ready_nxt_s = (state_nxt_s == ST_RUN);
    end

    // A write is honoured only in RUN; register 0 swallows writes when hardwired
    always_comb begin
        wr_en_s = 1'b0;
        if ((state_r == ST_RUN) && bus.RegWrite) begin
            if ((ZERO_R0 != 0) && (bus.WA == ADDR_ZERO)) begin
                wr_en_s = 1'b0;
            end else begin
                wr_en_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Read port 1 select: hardwired zero beats bypass, bypass beats stored data
    always_comb begin
        rd1_s = DATA_ZERO;
        if ((ZERO_R0 != 0) && (bus.RR1 == ADDR_ZERO)) begin
            rd1_s = DATA_ZERO;
        end else if ((BYPASS != 0) && wr_en_s && (bus.WA == bus.RR1)) begin
            rd1_s = bus.WD;
        end else begin
            rd1_s = regs_r[bus.RR1];
        end
    end

    // Read port 2 select, identical priority to port 1 so equal addresses match
    always_comb begin
        rd2_s = DATA_ZERO;
        if ((ZERO_R0 != 0) && (bus.RR2 == ADDR_ZERO)) begin
            rd2_s = DATA_ZERO;
        end else if ((BYPASS != 0) && wr_en_s && (bus.WA == bus.RR2)) begin
            rd2_s = bus.WD;
        end else begin
            rd2_s = regs_r[bus.RR2];
        end
    end

    // Control and output registers; read data is held at zero until RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INIT;
            cnt_r   <= ADDR_ZERO;
            ready_r <= 1'b0;
            dr1_r   <= DATA_ZERO;
            dr2_r   <= DATA_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= ready_nxt_s;
            if (state_r == ST_RUN) begin
                dr1_r <= rd1_s;
                dr2_r <= rd2_s;
            end else begin
                dr1_r <= DATA_ZERO;
                dr2_r <= DATA_ZERO;
            end
        end
    end

    // Storage array: cleared by the sweep, written by the user port in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r_unused_guard();
        end else if (sweep_en_s) begin
            regs_r[cnt_r] <= DATA_ZERO;
        end else if (wr_en_s) begin
            regs_r[bus.WA] <= bus.WD;
        end
    end

    // Reset drops any pending write; the array itself is cleared by the sweep
    function automatic void cnt_r_unused_guard();
    endfunction

    assign bus.DR1   = dr1_r;
    assign bus.DR2   = dr2_r;
    assign bus.ready = ready_r;

endmodule

// File: tb/tb_bdr_param.sv
// Directed self-checking bench for bdr_param: two 32x32 banks (bypass on/off)
// driven in lockstep plus a small 8x8 bank, checked with immediate assertions.
module tb_bdr_param;
    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we_c;
    logic [2:0]  rr1_c;
    logic [2:0]  rr2_c;
    logic [2:0]  wa_c;
    logic [7:0]  wd_c;
    int          n_cmp;
    int          n_err;

    bdr_param_if #(.DATA_W(32), .ADDR_W(5)) if_a ();
    bdr_param_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
    bdr_param_if #(.DATA_W(8),  .ADDR_W(3)) if_c ();

    assign if_a.RegWrite = we;
    assign if_a.RR1      = rr1;
    assign if_a.RR2      = rr2;
    assign if_a.WA       = wa;
    assign if_a.WD       = wd;
    assign if_b.RegWrite = we;
    assign if_b.RR1      = rr1;
    assign if_b.RR2      = rr2;
    assign if_b.WA       = wa;
    assign if_b.WD       = wd;
    assign if_c.RegWrite = we_c;
    assign if_c.RR1      = rr1_c;
    assign if_c.RR2      = rr2_c;
    assign if_c.WA       = wa_c;
    assign if_c.WD       = wd_c;

    bdr_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    bdr_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    bdr_param #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        we    = 1'b0;
        rr1   = 5'd0;
        rr2   = 5'd0;
        wa    = 5'd0;
        wd    = 32'd0;
        we_c  = 1'b0;
        rr1_c = 3'd0;
        rr2_c = 3'd0;
        wa_c  = 3'd0;
        wd_c  = 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst_ready_a", {31'd0, if_a.ready}, 32'd0);
        chk("rst_dr1_a", if_a.DR1, 32'd0);
        chk("rst_dr2_a", if_a.DR2, 32'd0);
        chk("rst_ready_c", {31'd0, if_c.ready}, 32'd0);

        // Sweep after release, with writes attempted during INIT
        rst = 1'b0;
        we  = 1'b1;
        wd  = 32'hFFFF_FFFF;
        for (int i = 1; i <= 32; i++) begin
            wa  = 5'(i - 1);
            rr1 = 5'(i - 1);
            rr2 = 5'(i + 3);
            tick();
            chk($sformatf("sweep_ready_a_%0d", i), {31'd0, if_a.ready}, (i == 32) ? 32'd1 : 32'd0);
            chk($sformatf("sweep_ready_b_%0d", i), {31'd0, if_b.ready}, (i == 32) ? 32'd1 : 32'd0);
            chk($sformatf("sweep_ready_c_%0d", i), {31'd0, if_c.ready}, (i >= 8) ? 32'd1 : 32'd0);
            chk($sformatf("sweep_dr1_a_%0d", i), if_a.DR1, 32'd0);
        end
        we = 1'b0;

        // Every entry reads back zero on both ports
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i);
            rr2 = 5'(31 - i);
            tick();
            chk($sformatf("clr_dr1_a_%0d", i), if_a.DR1, 32'd0);
            chk($sformatf("clr_dr2_a_%0d", i), if_a.DR2, 32'd0);
            chk($sformatf("clr_dr1_b_%0d", i), if_b.DR1, 32'd0);
        end

        // Small instance: write 7 then read it on both ports
        we_c = 1'b1;
        wa_c = 3'd7;
        wd_c = 8'hA5;
        tick();
        we_c  = 1'b0;
        rr1_c = 3'd7;
        rr2_c = 3'd7;
        tick();
        chk("c_dr1_7", {24'd0, if_c.DR1}, 32'h0000_00A5);
        chk("c_dr2_7", {24'd0, if_c.DR2}, 32'h0000_00A5);

        // Basic write then read
        we = 1'b1;
        wa = 5'd2;
        wd = 32'd11;
        tick();
        wa = 5'd3;
        wd = 32'd10;
        tick();
        we  = 1'b0;
        rr1 = 5'd2;
        rr2 = 5'd3;
        tick();
        chk("rd_dr1_a", if_a.DR1, 32'd11);
        chk("rd_dr2_a", if_a.DR2, 32'd10);
        chk("rd_dr1_b", if_b.DR1, 32'd11);
        chk("rd_dr2_b", if_b.DR2, 32'd10);

        // Same-cycle write/read of address 7
        rr1 = 5'd7;
        rr2 = 5'd7;
        we  = 1'b1;
        wa  = 5'd7;
        wd  = 32'hDEAD_BEEF;
        tick();
        chk("byp_dr1_a", if_a.DR1, 32'hDEAD_BEEF);
        chk("byp_dr2_a", if_a.DR2, 32'hDEAD_BEEF);
        chk("nobyp_dr1_b", if_b.DR1, 32'd0);
        chk("nobyp_dr2_b", if_b.DR2, 32'd0);
        wa = 5'd8;
        wd = 32'd5;
        tick();
        chk("byp_other_a", if_a.DR1, 32'hDEAD_BEEF);
        chk("late_dr1_b", if_b.DR1, 32'hDEAD_BEEF);

        // Hardwired register 0 under a write of all ones
        wa  = 5'd0;
        wd  = 32'hFFFF_FFFF;
        rr1 = 5'd0;
        rr2 = 5'd2;
        tick();
        chk("r0_byp_a", if_a.DR1, 32'd0);
        chk("r0_nobyp_b", if_b.DR1, 32'd0);
        chk("r0_dr2_a", if_a.DR2, 32'd11);
        we = 1'b0;
        tick();
        chk("r0_after_a", if_a.DR1, 32'd0);
        chk("r0_after_b", if_b.DR1, 32'd0);

        // Reset from RUN with a write on the same edge
        rr1 = 5'd7;
        tick();
        chk("pre_rst_dr1_a", if_a.DR1, 32'hDEAD_BEEF);
        rst = 1'b1;
        we  = 1'b1;
        wa  = 5'd4;
        wd  = 32'd99;
        tick();
        chk("run_rst_ready_a", {31'd0, if_a.ready}, 32'd0);
        chk("run_rst_dr1_a", if_a.DR1, 32'd0);
        rst = 1'b0;
        wd  = 32'hFFFF_FFFF;
        for (int i = 1; i <= 10; i++) begin
            wa = 5'(i + 10);
            tick();
            chk($sformatf("part_ready_a_%0d", i), {31'd0, if_a.ready}, 32'd0);
        end

        // Reset pulse at sweep cycle 10 restarts the full sweep
        rst = 1'b1;
        tick();
        chk("mid_rst_ready_a", {31'd0, if_a.ready}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            wa = 5'(i - 1);
            tick();
            chk($sformatf("resweep_ready_a_%0d", i), {31'd0, if_a.ready}, (i == 32) ? 32'd1 : 32'd0);
            chk($sformatf("resweep_ready_b_%0d", i), {31'd0, if_b.ready}, (i == 32) ? 32'd1 : 32'd0);
        end
        we  = 1'b0;
        rr1 = 5'd7;
        rr2 = 5'd4;
        rr1_c = 3'd7;
        tick();
        chk("post_dr1_a", if_a.DR1, 32'd0);
        chk("post_dr2_a", if_a.DR2, 32'd0);
        chk("post_dr1_b", if_b.DR1, 32'd0);
        chk("post_dr1_c", {24'd0, if_c.DR1}, 32'd0);
        rr1 = 5'd2;
        rr2 = 5'd31;
        tick();
        chk("post2_dr1_a", if_a.DR1, 32'd0);
        chk("post2_dr2_a", if_a.DR2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
